fnd_game_timer: RTL and testbench

FND_GAME_TIMER -- requirements
Module: fnd_game_timer

---
 rtl/fnd_pkg.sv | 18 +
 rtl/fnd_dec.sv | 11 +
 rtl/fnd_game_timer.sv | 135 +++++++++++++
 tb/tb_fnd_game_timer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared definitions for the FND game timer: FSM state encoding and the
// seven-segment lookup table (bit order {g,f,e,d,c,b,a}, 1 = lit).
package fnd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Codes 10..15 are not BCD digits and show as a blank digit.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };

endpackage

// File: rtl/fnd_dec.sv
// Single-digit BCD to seven-segment decoder, purely combinational.
module fnd_dec
  import fnd_pkg::*;
(
  input  logic [3:0] i_Bcd,
  output logic [6:0] o_Seg
);

  assign o_Seg = SEG_TABLE[i_Bcd];

endmodule

// File: rtl/fnd_game_timer.sv
// Multi-digit BCD game timer with start/stop/pause, clear and seven-segment
// outputs. Optional down-counting with preset is enabled by FND_TIMER_DOWN_EN.
module fnd_game_timer
  import fnd_pkg::*;
#(
  parameter int DIGITS  = 3,
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 20,
  parameter int WRAP    = 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_fStartStop,
  input  logic                  i_fClear,
`ifdef FND_TIMER_DOWN_EN
  input  logic                  i_fDown,
  input  logic [4*DIGITS-1:0]   i_Preset,
`endif
  output logic [4*DIGITS-1:0]   o_Bcd,
  output logic [7*DIGITS-1:0]   o_Fnd,
  output logic                  o_fRun,
  output logic                  o_fDone,
  output state_t                o_State
);

  localparam int PERIOD = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
  localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] TERM = PW'(PERIOD - 1);

  state_t                state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [4*DIGITS-1:0]   count_q, count_d;
  logic                  ss_q;

  logic                  start_edge, tick, down;
  logic [4*DIGITS-1:0]   preset;
  logic [4*DIGITS-1:0]   inc_val, dec_val;
  logic                  all_nines, all_zero;

`ifdef FND_TIMER_DOWN_EN
  assign down   = i_fDown;
  assign preset = i_Preset;
`else
  assign down   = 1'b0;
  assign preset = '0;
`endif

  assign start_edge = i_fStartStop & ~ss_q;
  assign tick       = (state_q == ST_RUN) && (presc_q == TERM);

  // Ripple-carry/borrow BCD step; carry (borrow) survives only through 9s (0s).
  always_comb begin : bcd_step
    logic       carry;
    logic       borrow;
    logic [3:0] dig;
    carry   = 1'b1;
    borrow  = 1'b1;
    dig     = 4'd0;
    inc_val = '0;
    dec_val = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count_q[4*i +: 4];
      inc_val[4*i +: 4] = carry  ? ((dig == 4'd9) ? 4'd0 : dig + 4'd1) : dig;
      dec_val[4*i +: 4] = borrow ? ((dig == 4'd0) ? 4'd9 : dig - 4'd1) : dig;
      carry  = carry  && (dig == 4'd9);
      borrow = borrow && (dig == 4'd0);
    end
    all_nines = carry;
    all_zero  = borrow;
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    if (i_fClear) begin
      state_d = ST_IDLE;
      presc_d = '0;
      count_d = down ? preset : '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_d = '0;
          if (start_edge) state_d = ST_RUN;
        end
        ST_RUN: begin
          // The prescaler keeps its period even when a pause swallows the tick.
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (start_edge) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            if (down) begin
              if (all_zero && (WRAP == 0)) state_d = ST_DONE;
              else                         count_d = dec_val;
            end else begin
              if (all_nines && (WRAP == 0)) state_d = ST_DONE;
              else                          count_d = inc_val;
            end
          end
        end
        ST_PAUSE: begin
          if (start_edge) state_d = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      count_q <= '0;
      ss_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      count_q <= count_d;
      ss_q    <= i_fStartStop;
    end
  end

  assign o_Bcd   = count_q;
  assign o_fRun  = (state_q == ST_RUN);
  assign o_fDone = (state_q == ST_DONE);
  assign o_State = state_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    fnd_dec u_dec (
      .i_Bcd (count_q[4*g +: 4]),
      .o_Seg (o_Fnd[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_fnd_game_timer.sv
// Bench for fnd_game_timer: two instances (wrapping and stopping) share one
// stimulus stream and are compared every cycle against a decimal-count model.
module tb_fnd_game_timer;

  localparam int P    = 10;
  localparam int MAXV = 999;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
`ifdef FND_TIMER_DOWN_EN
  localparam bit DOWN_EN = 1'b1;
`else
  localparam bit DOWN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ss = 1'b0;
  logic        clr = 1'b0;
  logic        down = 1'b0;
  logic [11:0] preset = 12'h000;

  logic [11:0] bcd_w, bcd_s;
  logic [20:0] fnd_w, fnd_s;
  logic        run_w, run_s, done_w, done_s;
  logic [1:0]  st_w, st_s;

  int n_total = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  int m_mode [2];
  int m_count[2];
  int m_phase[2];
  bit m_prev;

  always #5 clk = ~clk;

  fnd_game_timer #(.DIGITS(3), .CLK_HZ(100), .TICK_HZ(10), .WRAP(1)) u_wrap (
    .i_Clk(clk), .i_Rst(rst), .i_fStartStop(ss), .i_fClear(clr),
`ifdef FND_TIMER_DOWN_EN
    .i_fDown(down), .i_Preset(preset),
`endif
    .o_Bcd(bcd_w), .o_Fnd(fnd_w), .o_fRun(run_w), .o_fDone(done_w), .o_State(st_w)
  );

  fnd_game_timer #(.DIGITS(3), .CLK_HZ(100), .TICK_HZ(10), .WRAP(0)) u_stop (
    .i_Clk(clk), .i_Rst(rst), .i_fStartStop(ss), .i_fClear(clr),
`ifdef FND_TIMER_DOWN_EN
    .i_fDown(down), .i_Preset(preset),
`endif
    .o_Bcd(bcd_s), .o_Fnd(fnd_s), .o_fRun(run_s), .o_fDone(done_s), .o_State(st_s)
  );

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'h3F;  1: seg = 7'h06;  2: seg = 7'h5B;  3: seg = 7'h4F;
      4: seg = 7'h66;  5: seg = 7'h6D;  6: seg = 7'h7D;  7: seg = 7'h07;
      8: seg = 7'h7F;  9: seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    to_bcd = {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [20:0] to_fnd(input int v);
    to_fnd = {seg((v / 100) % 10), seg((v / 10) % 10), seg(v % 10)};
  endfunction

  function automatic int bcd2int(input logic [11:0] b);
    bcd2int = int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: count kept as a decimal integer, period phase counted in RUN cycles.
  always @(posedge clk or negedge rst) begin : model
    bit e;
    bit tk;
    if (!rst) begin
      m_prev = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = M_IDLE; m_count[k] = 0; m_phase[k] = 0;
      end
    end else begin
      e = ss && !m_prev;
      m_prev = ss;
      for (int k = 0; k < 2; k++) begin
        if (clr) begin
          m_mode[k]  = M_IDLE;
          m_phase[k] = 0;
          m_count[k] = (DOWN_EN && down) ? bcd2int(preset) : 0;
        end else if (m_mode[k] == M_IDLE) begin
          m_phase[k] = 0;
          if (e) m_mode[k] = M_RUN;
        end else if (m_mode[k] == M_PAUSE) begin
          if (e) m_mode[k] = M_RUN;
        end else if (m_mode[k] == M_RUN) begin
          tk = (m_phase[k] == P - 1);
          m_phase[k] = (m_phase[k] + 1) % P;
          if (e) m_mode[k] = M_PAUSE;
          else if (tk) begin
            if (DOWN_EN && down) begin
              if (m_count[k] == 0) begin
                if (k == 0) m_count[k] = MAXV; else m_mode[k] = M_DONE;
              end else m_count[k] = m_count[k] - 1;
            end else begin
              if (m_count[k] == MAXV) begin
                if (k == 0) m_count[k] = 0; else m_mode[k] = M_DONE;
              end else m_count[k] = m_count[k] + 1;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("wrap.bcd",  32'(bcd_w),  32'(to_bcd(m_count[0])));
      check("wrap.fnd",  32'(fnd_w),  32'(to_fnd(m_count[0])));
      check("wrap.run",  32'(run_w),  32'(m_mode[0] == M_RUN));
      check("wrap.done", 32'(done_w), 32'(m_mode[0] == M_DONE));
      check("wrap.st",   32'(st_w),   32'(m_mode[0]));
      check("stop.bcd",  32'(bcd_s),  32'(to_bcd(m_count[1])));
      check("stop.fnd",  32'(fnd_s),  32'(to_fnd(m_count[1])));
      check("stop.run",  32'(run_s),  32'(m_mode[1] == M_RUN));
      check("stop.done", 32'(done_s), 32'(m_mode[1] == M_DONE));
      check("stop.st",   32'(st_s),   32'(m_mode[1]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    ss = 1'b1;
    @(negedge clk);
    ss = 1'b0;
  endtask

  task automatic clear_pulse();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".bcd"},  32'(bcd_w),  32'h0);
    check({tag, ".fnd"},  32'(fnd_w),  32'({3{7'h3F}}));
    check({tag, ".run"},  32'(run_w),  32'h0);
    check({tag, ".done"}, 32'(done_s), 32'h0);
    check({tag, ".st"},   32'(st_s),   32'h0);
  endtask

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    cyc(2);
    check_reset_outputs("reset");
    rst = 1'b1;

    // Start and run 25 cycles: ticks after 10 and 20 cycles.
    pulse();
    cyc(25);
    check("run25.bcd", 32'(bcd_w), 32'h002);
    check("run25.run", 32'(run_w), 32'h1);
    check("run25.seg0", 32'(fnd_w[6:0]), 32'h5B);

    // Pause four cycles into a period, sit 100 cycles, resume.
    cyc(8);
    pulse();
    cyc(100);
    check("pause.bcd", 32'(bcd_w), 32'h003);
    check("pause.st",  32'(st_w),  32'h2);
    pulse();
    cyc(5);
    check("resume5.bcd", 32'(bcd_w), 32'h003);
    cyc(1);
    check("resume6.bcd", 32'(bcd_w), 32'h004);

    // Clear together with a start/stop edge while running.
    ss = 1'b1; clr = 1'b1;
    @(negedge clk);
    ss = 1'b0; clr = 1'b0;
    check("clr_edge.st",  32'(st_w),  32'h0);
    check("clr_edge.bcd", 32'(bcd_w), 32'h0);
    check("clr_edge.run", 32'(run_w), 32'h0);

    // Randomized start/stop pulses of varying width, idle gaps and clears.
    for (int it = 0; it < 60; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6) begin
        cyc(int'($urandom_range(1, 25)));
      end else if (r < 9) begin
        ss = 1'b1;
        cyc(int'($urandom_range(1, 3)));
        ss = 1'b0;
      end else begin
        if (DOWN_EN) begin
          down   = 1'($urandom_range(0, 1));
          preset = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        end
        clear_pulse();
      end
    end
    down = 1'b0;

    // Terminal count: wrap vs stop-in-DONE.
    clear_pulse();
    pulse();
    cyc(9995);
    check("n999.wrap", 32'(bcd_w), 32'h999);
    check("n999.stop", 32'(bcd_s), 32'h999);
    cyc(6);
    check("term.wrap.bcd", 32'(bcd_w),  32'h000);
    check("term.wrap.run", 32'(run_w),  32'h1);
    check("term.stop.bcd", 32'(bcd_s),  32'h999);
    check("term.stop.done", 32'(done_s), 32'h1);
    pulse();
    cyc(20);
    check("done_edge.stop.st",  32'(st_s),  32'h3);
    check("done_edge.stop.bcd", 32'(bcd_s), 32'h999);
    check("done_edge.wrap.st",  32'(st_w),  32'h2);

    // Asynchronous reset mid-period at count 057, then a full first period.
    clear_pulse();
    pulse();
    cyc(575);
    check("pre_rst.bcd", 32'(bcd_w), 32'h057);
    #3 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;
    pulse();
    cyc(9);
    check("restart9.bcd", 32'(bcd_w), 32'h000);
    cyc(1);
    check("restart10.bcd", 32'(bcd_w), 32'h001);

`ifdef FND_TIMER_DOWN_EN
    // Down count from preset 010; the tick taken at zero ends the run.
    down = 1'b1;
    preset = 12'h010;
    clear_pulse();
    check("preset.bcd", 32'(bcd_s), 32'h010);
    pulse();
    cyc(100);
    check("down100.bcd", 32'(bcd_s), 32'h000);
    cyc(10);
    check("down.stop.bcd",  32'(bcd_s),  32'h000);
    check("down.stop.done", 32'(done_s), 32'h1);
    check("down.wrap.bcd",  32'(bcd_w),  32'h999);
    down = 1'b0;
`endif

    cyc(3);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
